// File: rtl/cordic_outputs.sv
// cordic_outputs: captures CORDIC results, tracks done/overrun/busy status, drives irq, serves a one-cycle-latency read bus
module cordic_outputs #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  bus_addr,
  input  logic        bus_rd,
  output logic [31:0] bus_data_out,
  output logic        bus_rd_valid,
  input  logic        start_in,
  input  logic        cordic_done,
  input  logic [31:0] X_out,
  input  logic [31:0] Y_out,
  input  logic [31:0] Z_out,
  output logic        irq
);
  logic [31:0]      r_res_x, r_res_y, r_res_z;
  logic [31:0]      r_shadow_y, r_shadow_z;
  logic             r_done_flag, r_overrun, r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_start_q, r_start_primed;
  logic             w_stat_rd, w_res_rd, w_start_rise;
  logic [31:0]      w_status, w_cnt_ext, w_rd_data;
  assign w_stat_rd    = bus_rd && bus_addr == 6'd3;
  assign w_res_rd     = bus_rd && bus_addr == 6'd0;
  assign w_start_rise = r_start_primed & start_in & ~r_start_q;
  assign w_status     = {29'b0, r_overrun, r_busy, r_done_flag};
  assign w_cnt_ext    = 32'(r_count);
  assign irq          = r_done_flag;
  // read mux sees pre-update state, so coincident events return old values
  always_comb begin
    w_rd_data = bus_addr == 6'd0 ? r_res_x    :
                bus_addr == 6'd1 ? r_shadow_y :
                bus_addr == 6'd2 ? r_shadow_z :
                bus_addr == 6'd3 ? w_status   :
                bus_addr == 6'd4 ? w_cnt_ext  : 32'd0;
  end
  // result capture; an address-0 read freezes the matching Y/Z into the shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_x    <= '0;
      r_res_y    <= '0;
      r_res_z    <= '0;
      r_shadow_y <= '0;
      r_shadow_z <= '0;
    end else begin
      if (cordic_done) begin
        r_res_x <= X_out;
        r_res_y <= Y_out;
        r_res_z <= Z_out;
      end
      if (w_res_rd) begin
        r_shadow_y <= r_res_y;
        r_shadow_z <= r_res_z;
      end
    end
  end
  // status flags: done wins over clear-on-read, overrun only when an unread result is replaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_flag <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done_flag <= cordic_done | (r_done_flag & ~w_stat_rd);
      r_overrun   <= ~w_stat_rd & (r_overrun | (cordic_done & r_done_flag));
      r_busy      <= ~cordic_done & (r_busy | w_start_rise);
    end
  end
  // start edge detect; the first sample after reset only primes the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q      <= 1'b0;
      r_start_primed <= 1'b0;
    end else begin
      r_start_q      <= start_in;
      r_start_primed <= 1'b1;
    end
  end
  // wrapping result counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (cordic_done) r_count <= r_count + CNT_W'(1);
  end
  // registered read port; data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data_out <= '0;
      bus_rd_valid <= 1'b0;
    end else begin
      bus_rd_valid <= bus_rd;
      if (bus_rd) bus_data_out <= w_rd_data;
    end
  end
endmodule

// File: tb/tb_cordic_outputs.sv
// tb_cordic_outputs: directed checks of result capture, status, shadows, counter wrap and reset
module tb_cordic_outputs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  bus_addr = '0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_data_out;
  logic        bus_rd_valid;
  logic        start_in = 1'b1;
  logic        cordic_done = 1'b0;
  logic [31:0] X_out = '0, Y_out = '0, Z_out = '0;
  logic        irq;
  int          errs = 0, checks = 0, exp_cnt = 0;
  logic [31:0] d;
  logic        v;

  cordic_outputs #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_rd(bus_rd),
    .bus_data_out(bus_data_out), .bus_rd_valid(bus_rd_valid),
    .start_in(start_in), .cordic_done(cordic_done),
    .X_out(X_out), .Y_out(Y_out), .Z_out(Z_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic rd(input logic [5:0] a, output logic [31:0] data, output logic valid);
    bus_addr = a;
    bus_rd = 1'b1;
    @(posedge clk); #1;
    bus_rd = 1'b0;
    data = bus_data_out;
    valid = bus_rd_valid;
  endtask

  task automatic set_res(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    X_out = x; Y_out = y; Z_out = z;
    cordic_done = 1'b1;
  endtask

  task automatic pulse(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    set_res(x, y, z);
    @(posedge clk); #1;
    cordic_done = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus_data_out !== 32'd0 || bus_rd_valid !== 1'b0 || irq !== 1'b0) begin
      errs++; $display("FAIL reset_outputs got data=%h valid=%b irq=%b exp 0/0/0", bus_data_out, bus_rd_valid, irq);
    end
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd(6'd3, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin
      errs++; $display("FAIL start_high_after_reset status got %h valid %b exp 00000000 1", d, v);
    end
    rd(6'd4, d, v);
    checks++; if (d !== 32'h0) begin
      errs++; $display("FAIL reset_count got %h exp 00000000", d);
    end
  endtask

  task automatic test_start_edge;
    start_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_in = 1'b1;
    @(posedge clk); #1;
    rd(6'd3, d, v);
    checks++; if (d !== 32'h2) begin
      errs++; $display("FAIL busy_on_edge status got %h exp 00000002", d);
    end
  endtask

  task automatic test_basic;
    pulse(32'h00010000, 32'hFFFF0000, 32'h12345678);
    checks++; if (irq !== 1'b1) begin
      errs++; $display("FAIL irq_after_done got %b exp 1", irq);
    end
    rd(6'd0, d, v);
    checks++; if (d !== 32'h00010000 || v !== 1'b1) begin
      errs++; $display("FAIL read_x got %h valid %b exp 00010000 1", d, v);
    end
    @(posedge clk); #1;
    checks++; if (bus_rd_valid !== 1'b0 || bus_data_out !== 32'h00010000) begin
      errs++; $display("FAIL idle_hold got valid %b data %h exp 0 00010000", bus_rd_valid, bus_data_out);
    end
    rd(6'd1, d, v);
    checks++; if (d !== 32'hFFFF0000 || v !== 1'b1) begin
      errs++; $display("FAIL read_y got %h valid %b exp ffff0000 1", d, v);
    end
    rd(6'd2, d, v);
    checks++; if (d !== 32'h12345678 || v !== 1'b1) begin
      errs++; $display("FAIL read_z got %h valid %b exp 12345678 1", d, v);
    end
    rd(6'd3, d, v);
    checks++; if (d !== 32'h1) begin
      errs++; $display("FAIL status_after_done got %h exp 00000001 (busy cleared)", d);
    end
    checks++; if (irq !== 1'b0) begin
      errs++; $display("FAIL irq_after_status_read got %b exp 0", irq);
    end
  endtask

  task automatic test_overrun;
    pulse(32'hA0, 32'hA1, 32'hA2);
    pulse(32'hB0, 32'hAAAA0001, 32'hB2);
    rd(6'd3, d, v);
    checks++; if (d !== 32'h5) begin
      errs++; $display("FAIL overrun_status got %h exp 00000005", d);
    end
    rd(6'd3, d, v);
    checks++; if (d !== 32'h0 || irq !== 1'b0) begin
      errs++; $display("FAIL overrun_cleared got %h irq %b exp 00000000 0", d, irq);
    end
  endtask

  task automatic test_shadow;
    rd(6'd0, d, v);
    pulse(32'hC1, 32'h00000007, 32'hC3);
    rd(6'd1, d, v);
    checks++; if (d !== 32'hAAAA0001) begin
      errs++; $display("FAIL shadow_y_coherent got %h exp aaaa0001", d);
    end
    rd(6'd0, d, v);
    rd(6'd1, d, v);
    checks++; if (d !== 32'h00000007) begin
      errs++; $display("FAIL shadow_y_refresh got %h exp 00000007", d);
    end
  endtask

  task automatic test_coincident;
    set_res(32'h22, 32'h33, 32'h44);
    rd(6'd0, d, v);
    cordic_done = 1'b0; exp_cnt++;
    checks++; if (d !== 32'hC1) begin
      errs++; $display("FAIL x_read_with_done got %h exp 000000c1", d);
    end
    rd(6'd1, d, v);
    checks++; if (d !== 32'h7) begin
      errs++; $display("FAIL shadow_y_with_done got %h exp 00000007", d);
    end
    rd(6'd2, d, v);
    checks++; if (d !== 32'hC3) begin
      errs++; $display("FAIL shadow_z_with_done got %h exp 000000c3", d);
    end
    rd(6'd0, d, v);
    checks++; if (d !== 32'h22) begin
      errs++; $display("FAIL new_x_after_done got %h exp 00000022", d);
    end
    set_res(32'h55, 32'h66, 32'h77);
    rd(6'd4, d, v);
    cordic_done = 1'b0;
    checks++; if (d !== 32'(exp_cnt)) begin
      errs++; $display("FAIL count_with_done got %h exp %h", d, 32'(exp_cnt));
    end
    exp_cnt++;
    rd(6'd4, d, v);
    checks++; if (d !== 32'(exp_cnt)) begin
      errs++; $display("FAIL count_after_done got %h exp %h", d, 32'(exp_cnt));
    end
  endtask

  task automatic test_status_with_done;
    rd(6'd3, d, v);
    pulse(32'h1, 32'h2, 32'h3);
    pulse(32'h4, 32'h5, 32'h6);
    set_res(32'h7, 32'h8, 32'h9);
    rd(6'd3, d, v);
    cordic_done = 1'b0; exp_cnt++;
    checks++; if (d !== 32'h5) begin
      errs++; $display("FAIL status_with_done got %h exp 00000005", d);
    end
    rd(6'd3, d, v);
    checks++; if (d !== 32'h1) begin
      errs++; $display("FAIL status_after_coincident got %h exp 00000001", d);
    end
  endtask

  task automatic test_count_wrap;
    X_out = 32'h5A5A5A5A;
    cordic_done = 1'b1;
    repeat (65535 - exp_cnt) @(posedge clk);
    #1 cordic_done = 1'b0;
    exp_cnt = 65535;
    rd(6'd4, d, v);
    checks++; if (d !== 32'h0000FFFF) begin
      errs++; $display("FAIL count_full got %h exp 0000ffff", d);
    end
    pulse(32'h5A5A5A5A, 32'h0, 32'h0);
    rd(6'd4, d, v);
    checks++; if (d !== 32'h0) begin
      errs++; $display("FAIL count_wrap got %h exp 00000000", d);
    end
    rd(6'd9, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin
      errs++; $display("FAIL unmapped got %h valid %b exp 00000000 1", d, v);
    end
  endtask

  task automatic test_reset_midread;
    rd(6'd0, d, v);
    checks++; if (d !== 32'h5A5A5A5A || irq !== 1'b1) begin
      errs++; $display("FAIL pre_reset got %h irq %b exp 5a5a5a5a 1", d, irq);
    end
    bus_addr = 6'd3;
    bus_rd = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_data_out !== 32'd0 || bus_rd_valid !== 1'b0 || irq !== 1'b0) begin
      errs++; $display("FAIL async_reset got data=%h valid=%b irq=%b exp 0/0/0", bus_data_out, bus_rd_valid, irq);
    end
    @(posedge clk); #1;
    bus_rd = 1'b0;
    checks++; if (bus_rd_valid !== 1'b0) begin
      errs++; $display("FAIL suppressed_valid got %b exp 0", bus_rd_valid);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd(6'd3, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin
      errs++; $display("FAIL status_after_reset got %h valid %b exp 00000000 1", d, v);
    end
  endtask

  initial begin
    test_reset;
    test_start_edge;
    test_basic;
    test_overrun;
    test_shadow;
    test_coincident;
    test_status_with_done;
    test_count_wrap;
    test_reset_midread;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cordic_outputs.md
CORDIC_OUTPUTS -- requirements
Module: cordic_outputs

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the result counter.
REQ-002 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have bus_addr  input  6  read address.
REQ-005 SHALL have bus_rd  input  1  read strobe, one cycle per access.
REQ-006 SHALL have bus_data_out  output  32  registered read data.
REQ-007 SHALL have bus_rd_valid  output  1  one-cycle pulse qualifying bus_data_out.
REQ-008 SHALL have start_in  input  1  level start bit from the input register block.
REQ-009 SHALL have cordic_done  input  1  one-cycle pulse; result inputs valid this cycle.
REQ-010 SHALL have X_out, Y_out, Z_out  input  32 each  signed CORDIC results.
REQ-011 SHALL have irq  output  1  level; equals done_flag.

Function
REQ-012 SHALL latch X_out/Y_out/Z_out into res_x/res_y/res_z on the cycle cordic_done=1.
REQ-013 SHALL set done_flag on cordic_done; done_flag SHALL hold until cleared by a status read.
REQ-014 SHALL set overrun on cordic_done when done_flag=1 and no status read occurs that cycle; sticky until status read.
REQ-015 SHALL set busy on a 0->1 transition of start_in (registered edge detect); SHALL clear busy on cordic_done; cordic_done wins if both occur in one cycle.
REQ-016 SHALL increment a CNT_W-bit result count on each cordic_done, wrapping all-ones -> 0.
REQ-017 Address map: 0 = res_x; 1 = shadow_y; 2 = shadow_z; 3 = status {29'b0, overrun, busy, done_flag}; 4 = zero-extended count; others = 0.
REQ-018 A read of address 0 SHALL copy res_y, res_z into shadow_y, shadow_z (coherent triple read).
REQ-019 Read latency SHALL be one cycle: bus_rd at cycle N -> bus_data_out valid and bus_rd_valid=1 at cycle N+1.
REQ-020 bus_rd_valid SHALL be 0 in every cycle not following a bus_rd; bus_data_out SHALL hold its last value then.
REQ-021 A read of address 3 SHALL return pre-clear values and SHALL clear done_flag and overrun.
REQ-022 Status read coincident with cordic_done: returns old status; afterwards done_flag=1, overrun=0.
REQ-023 Address-0 read coincident with cordic_done: returns old res_x; shadows get old res_y/res_z; res_* take new values.
REQ-024 Address-4 read coincident with cordic_done SHALL return the pre-increment count.
REQ-025 Reads of addresses 1, 2, 4 and unmapped addresses SHALL have no side effects.

Reset
REQ-026 rst_n=0 SHALL immediately clear res_*, shadow_*, done_flag, overrun, busy, count, start edge register, bus_data_out, bus_rd_valid, irq to 0.
REQ-027 Reset asserted mid-read SHALL suppress the pending bus_rd_valid pulse.
REQ-028 After rst_n release, a start_in already at 1 SHALL NOT set busy (edge register reset to 0 but edge requires a registered 0 sample; first sample only primes the register).

Verification
REQ-029 start_in 0->1, then cordic_done with X=0x00010000, Y=0xFFFF0000, Z=0x12345678 -> busy 1 then 0, irq=1, read addr 0,1,2 returns those values with bus_rd_valid one cycle after each bus_rd.
REQ-030 Two cordic_done pulses with no status read -> status read returns 0x5 (overrun, done), following status read returns 0x0, irq=0.
REQ-031 Read addr 0, then cordic_done with new Y=0x00000007, then read addr 1 -> returns previous Y, not 0x00000007.
REQ-032 Status read in same cycle as cordic_done with done_flag=1 -> returns 0x5; next status read returns 0x1.
REQ-033 Preload count to 0xFFFF via 65535 done pulses, one more pulse -> addr 4 reads 0x00000000; addr 9 reads 0x00000000.
REQ-034 Assert rst_n=0 between bus_rd and its valid cycle with done_flag=1 -> no bus_rd_valid, all outputs 0 asynchronously, status reads 0x0 after release.
